// File: rtl/proc16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proc16_pkg
//  Description : Types and widths shared between processor_16b and its
//                power-up boot loader.
//  Revision    : 1.0  initial release
// ============================================================================
package proc16_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    // Boot loader sequencing states.
    typedef enum logic [2:0] {
        BL_IDLE  = 3'd0,
        BL_LEN   = 3'd1,
        BL_LOAD  = 3'd2,
        BL_DRAIN = 3'd3,
        BL_RUN   = 3'd4
    } bl_state_e;

endpackage
`default_nettype wire

// File: rtl/boot_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : boot_loader_if
//  Description : Valid/ready word stream feeding the boot loader.
//                master : word source (host / UART side)
//                slave  : boot loader
//                Signals: s_valid, s_data[DATA_W], s_ready
//  Revision    : 1.0  initial release
// ============================================================================
interface boot_loader_if #(
    parameter int DATA_W = 16
) ();
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface
`default_nettype wire

// File: rtl/mem_port_mux.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_mux
//  Description : Selects who drives the shared program memory port: the
//                loader's registered write while loading, or the CPU's
//                signals (pure combinational passthrough) once running.
//  Ports       : run_sel_i                      1 = CPU owns the port
//                ld_addr_i/ld_wdata_i/ld_we_i   loader registered write
//                cpu_addr_i/cpu_wdata_i/cpu_we_i CPU memory signals
//                mem_addr_o/mem_wdata_o/mem_we_o memory port
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_mux #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  wire logic              run_sel_i,
    input  wire logic [ADDR_W-1:0] ld_addr_i,
    input  wire logic [DATA_W-1:0] ld_wdata_i,
    input  wire logic              ld_we_i,
    input  wire logic [ADDR_W-1:0] cpu_addr_i,
    input  wire logic [DATA_W-1:0] cpu_wdata_i,
    input  wire logic              cpu_we_i,
    output logic      [ADDR_W-1:0] mem_addr_o,
    output logic      [DATA_W-1:0] mem_wdata_o,
    output logic                   mem_we_o
);

    always_comb begin
        mem_addr_o  = ld_addr_i;
        mem_wdata_o = ld_wdata_i;
        mem_we_o    = ld_we_i;
        if (run_sel_i) begin
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
            mem_we_o    = cpu_we_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : boot_loader
//  Description : Power-up sequencer for processor_16b. Holds the CPU in reset,
//                receives a length-prefixed image on a valid/ready stream,
//                writes it to memory from BASE_ADDR, drains the last write,
//                then releases the CPU and hands it the memory port.
//  Ports       : clk, rst           clock, synchronous active-high reset
//                start              pulse: begin / restart a load
//                s (slave modport)  s_valid, s_data, s_ready
//                cpu_addr/cpu_wdata/cpu_we   CPU memory signals
//                cpu_rst            reset to the processor
//                mem_addr/mem_wdata/mem_we   memory port
//                busy, done         status (LEN/LOAD/DRAIN, RUN)
//                words_loaded       words written in current/last load
//                load_sum           mod-2^DATA_W sum of loaded words
//  Revision    : 1.0  initial release
// ============================================================================
module boot_loader
    import proc16_pkg::*;
#(
    parameter int              ADDR_W    = proc16_pkg::ADDR_W,
    parameter int              DATA_W    = proc16_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    boot_loader_if.slave           s,
    input  wire logic [ADDR_W-1:0] cpu_addr,
    input  wire logic [DATA_W-1:0] cpu_wdata,
    input  wire logic              cpu_we,
    output logic                   cpu_rst,
    output logic      [ADDR_W-1:0] mem_addr,
    output logic      [DATA_W-1:0] mem_wdata,
    output logic                   mem_we,
    output logic                   busy,
    output logic                   done,
    output logic      [ADDR_W-1:0] words_loaded,
    output logic      [DATA_W-1:0] load_sum
);

    bl_state_e         state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_we_q, wr_we_d;

    logic              w_hs;
    logic [ADDR_W-1:0] w_words_inc;

    // Status decoded from registered state only.
    assign s.s_ready    = (state_q == BL_LEN) || (state_q == BL_LOAD);
    assign busy         = (state_q == BL_LEN) || (state_q == BL_LOAD) || (state_q == BL_DRAIN);
    assign done         = (state_q == BL_RUN);
    assign cpu_rst      = (state_q != BL_RUN);
    assign words_loaded = words_q;
    assign load_sum     = sum_q;

    assign w_hs        = s.s_valid && s.s_ready;
    assign w_words_inc = words_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BL_IDLE;
            len_q     <= '0;
            ptr_q     <= '0;
            words_q   <= '0;
            sum_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            ptr_q     <= ptr_d;
            words_q   <= words_d;
            sum_q     <= sum_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_we_q   <= wr_we_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        ptr_d     = ptr_q;
        words_d   = words_q;
        sum_d     = sum_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        // Write strobe lives for exactly one cycle after a LOAD handshake.
        wr_we_d   = 1'b0;

        case (state_q)
            BL_IDLE: begin
                if (start) state_d = BL_LEN;
            end
            BL_LEN: begin
                // A start here is ignored: we are already waiting for a length.
                if (w_hs) begin
                    len_d   = ADDR_W'(s.s_data);
                    words_d = '0;
                    sum_d   = '0;
                    ptr_d   = BASE_ADDR;
                    state_d = (s.s_data == '0) ? BL_DRAIN : BL_LOAD;
                end
            end
            BL_LOAD: begin
                // Restart wins over a coincident handshake; that word is dropped
                // and no write is issued for it.
                if (start) begin
                    state_d = BL_LEN;
                end else if (w_hs) begin
                    wr_addr_d = ptr_q;
                    wr_data_d = s.s_data;
                    wr_we_d   = 1'b1;
                    ptr_d     = ptr_q + ADDR_W'(1);
                    words_d   = w_words_inc;
                    sum_d     = sum_q + s.s_data;
                    if (w_words_inc == len_q) state_d = BL_DRAIN;
                end
            end
            BL_DRAIN: begin
                state_d = start ? BL_LEN : BL_RUN;
            end
            BL_RUN: begin
                if (start) state_d = BL_LEN;
            end
            default: state_d = BL_IDLE;
        endcase
    end

    mem_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_port_mux (
        .run_sel_i   (state_q == BL_RUN),
        .ld_addr_i   (wr_addr_q),
        .ld_wdata_i  (wr_data_q),
        .ld_we_i     (wr_we_q),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_we_i    (cpu_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_we_o    (mem_we)
    );

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boot_loader
//  Description : Directed self-checking bench for boot_loader. A second
//                instance with BASE_ADDR = 16'hFFFE covers address wrap and
//                reset during a load.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Primary instance (BASE_ADDR = 0)
    logic        rst, start, cpu_we, cpu_rst, mem_we, busy, done;
    logic [15:0] cpu_addr, cpu_wdata, mem_addr, mem_wdata, words_loaded, load_sum;
    boot_loader_if #(.DATA_W(16)) bus ();

    // Wrap instance (BASE_ADDR = FFFE)
    logic        w_rst, w_start, w_cpu_we, w_cpu_rst, w_mem_we, w_busy, w_done;
    logic [15:0] w_cpu_addr, w_cpu_wdata, w_mem_addr, w_mem_wdata, w_words, w_sum;
    boot_loader_if #(.DATA_W(16)) wbus ();

    boot_loader #(.ADDR_W(16), .DATA_W(16), .BASE_ADDR(16'h0000)) u_dut (
        .clk (clk), .rst (rst), .start (start), .s (bus.slave),
        .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata), .cpu_we (cpu_we),
        .cpu_rst (cpu_rst), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
        .mem_we (mem_we), .busy (busy), .done (done),
        .words_loaded (words_loaded), .load_sum (load_sum)
    );

    boot_loader #(.ADDR_W(16), .DATA_W(16), .BASE_ADDR(16'hFFFE)) u_wrap (
        .clk (clk), .rst (w_rst), .start (w_start), .s (wbus.slave),
        .cpu_addr (w_cpu_addr), .cpu_wdata (w_cpu_wdata), .cpu_we (w_cpu_we),
        .cpu_rst (w_cpu_rst), .mem_addr (w_mem_addr), .mem_wdata (w_mem_wdata),
        .mem_we (w_mem_we), .busy (w_busy), .done (w_done),
        .words_loaded (w_words), .load_sum (w_sum)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the primary memory port: a write with the given address/data, or none.
    task automatic chk_wr(input string tag, input logic we, input logic [15:0] a, input logic [15:0] d);
        check({tag, ".we"}, {31'd0, mem_we}, {31'd0, we});
        if (we) begin
            check({tag, ".addr"}, {16'd0, mem_addr}, {16'd0, a});
            check({tag, ".data"}, {16'd0, mem_wdata}, {16'd0, d});
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        w_rst = 1'b1; w_start = 1'b0; w_cpu_addr = '0; w_cpu_wdata = '0; w_cpu_we = 1'b0;
        wbus.s_valid = 1'b0; wbus.s_data = '0;
        repeat (2) tick();
        rst = 1'b0; w_rst = 1'b0;

        // ---------------- Reset state ----------------
        repeat (5) tick();
        check("rst.cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst.s_ready", {31'd0, bus.s_ready}, 32'd0);
        check("rst.done",    {31'd0, done}, 32'd0);
        check("rst.busy",    {31'd0, busy}, 32'd0);
        check("rst.words",   {16'd0, words_loaded}, 32'd0);
        check("rst.sum",     {16'd0, load_sum}, 32'd0);
        chk_wr("rst", 1'b0, 16'h0, 16'h0);
        check("rst.addr",    {16'd0, mem_addr}, 32'd0);

        // ---------------- Basic load ----------------
        start = 1'b1; tick(); start = 1'b0;
        check("basic.len_ready", {31'd0, bus.s_ready}, 32'd1);
        bus.s_valid = 1'b1; bus.s_data = 16'd3; tick();
        chk_wr("basic.len", 1'b0, 16'h0, 16'h0);
        bus.s_data = 16'hA000; tick(); chk_wr("basic.w0", 1'b1, 16'h0000, 16'hA000);
        bus.s_data = 16'hA001; tick(); chk_wr("basic.w1", 1'b1, 16'h0001, 16'hA001);
        bus.s_data = 16'hA002; tick(); chk_wr("basic.w2", 1'b1, 16'h0002, 16'hA002);
        bus.s_valid = 1'b0;
        check("basic.drain_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("basic.drain_ready",   {31'd0, bus.s_ready}, 32'd0);
        check("basic.words", {16'd0, words_loaded}, 32'd3);
        check("basic.sum",   {16'd0, load_sum}, 32'hE003);
        tick();
        check("basic.run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("basic.run_done",    {31'd0, done}, 32'd1);
        chk_wr("basic.run_idle", 1'b0, 16'h0, 16'h0);
        cpu_addr = 16'h0042; cpu_wdata = 16'hBEEF; cpu_we = 1'b1; #1;
        chk_wr("basic.pass", 1'b1, 16'h0042, 16'hBEEF);
        cpu_we = 1'b0;

        // ---------------- Stalled stream ----------------
        start = 1'b1; tick(); start = 1'b0;
        check("stall.restart_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        bus.s_valid = 1'b1; bus.s_data = 16'd2; tick(); bus.s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); chk_wr("stall.gap0", 1'b0, 16'h0, 16'h0);
            check("stall.gap0_words", {16'd0, words_loaded}, 32'd0);
        end
        bus.s_valid = 1'b1; bus.s_data = 16'h1111; tick(); bus.s_valid = 1'b0;
        chk_wr("stall.w0", 1'b1, 16'h0000, 16'h1111);
        for (int i = 0; i < 4; i++) begin
            tick(); chk_wr("stall.gap1", 1'b0, 16'h0, 16'h0);
            check("stall.gap1_words", {16'd0, words_loaded}, 32'd1);
            check("stall.gap1_busy", {31'd0, busy}, 32'd1);
        end
        bus.s_valid = 1'b1; bus.s_data = 16'h2222; tick(); bus.s_valid = 1'b0;
        chk_wr("stall.w1", 1'b1, 16'h0001, 16'h2222);
        check("stall.drain_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("stall.sum", {16'd0, load_sum}, 32'h3333);
        tick();
        check("stall.run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("stall.words", {16'd0, words_loaded}, 32'd2);

        // ---------------- Zero length ----------------
        start = 1'b1; tick(); start = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 16'd0; tick(); bus.s_valid = 1'b0;
        chk_wr("zero.drain", 1'b0, 16'h0, 16'h0);
        check("zero.drain_busy", {31'd0, busy}, 32'd1);
        check("zero.drain_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        tick();
        check("zero.run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("zero.words", {16'd0, words_loaded}, 32'd0);
        chk_wr("zero.run", 1'b0, 16'h0, 16'h0);

        // ---------------- Restart mid-load ----------------
        start = 1'b1; tick(); start = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 16'd4; tick();
        bus.s_data = 16'h0AAA; tick(); chk_wr("rs.w0", 1'b1, 16'h0000, 16'h0AAA);
        bus.s_data = 16'h0BBB; tick(); chk_wr("rs.w1", 1'b1, 16'h0001, 16'h0BBB);
        // start coincides with a third offered word: that write must not happen
        bus.s_data = 16'h0CCC; start = 1'b1; tick(); start = 1'b0; bus.s_valid = 1'b0;
        chk_wr("rs.cancel", 1'b0, 16'h0, 16'h0);
        check("rs.len_ready", {31'd0, bus.s_ready}, 32'd1);
        check("rs.cpu_rst",   {31'd0, cpu_rst}, 32'd1);
        bus.s_valid = 1'b1; bus.s_data = 16'd1; tick();
        check("rs.words_clr", {16'd0, words_loaded}, 32'd0);
        bus.s_data = 16'h1234; tick(); bus.s_valid = 1'b0;
        chk_wr("rs.new", 1'b1, 16'h0000, 16'h1234);
        check("rs.words", {16'd0, words_loaded}, 32'd1);
        tick();
        check("rs.run", {31'd0, done}, 32'd1);

        // ---------------- Wrap (BASE_ADDR = FFFE) ----------------
        w_start = 1'b1; tick(); w_start = 1'b0;
        wbus.s_valid = 1'b1; wbus.s_data = 16'd3; tick();
        wbus.s_data = 16'h0001; tick();
        check("wrap.a0", {15'd0, w_mem_we, w_mem_addr}, {15'd0, 1'b1, 16'hFFFE});
        wbus.s_data = 16'h0002; tick();
        check("wrap.a1", {15'd0, w_mem_we, w_mem_addr}, {15'd0, 1'b1, 16'hFFFF});
        wbus.s_data = 16'h0003; tick(); wbus.s_valid = 1'b0;
        check("wrap.a2", {15'd0, w_mem_we, w_mem_addr}, {15'd0, 1'b1, 16'h0000});
        check("wrap.d2", {16'd0, w_mem_wdata}, 32'h0003);
        tick();
        check("wrap.done", {31'd0, w_done}, 32'd1);
        check("wrap.sum",  {16'd0, w_sum}, 32'h0006);

        // ---------------- Reset during a load ----------------
        w_start = 1'b1; tick(); w_start = 1'b0;
        wbus.s_valid = 1'b1; wbus.s_data = 16'd5; tick();
        wbus.s_data = 16'h0007; tick();
        check("abort.pre_we", {31'd0, w_mem_we}, 32'd1);
        wbus.s_data = 16'h0008; w_rst = 1'b1; tick(); w_rst = 1'b0; wbus.s_valid = 1'b0;
        check("abort.we",      {31'd0, w_mem_we}, 32'd0);
        check("abort.cpu_rst", {31'd0, w_cpu_rst}, 32'd1);
        check("abort.ready",   {31'd0, wbus.s_ready}, 32'd0);
        check("abort.busy",    {31'd0, w_busy}, 32'd0);
        check("abort.words",   {16'd0, w_words}, 32'd0);
        tick();
        check("abort.we2",      {31'd0, w_mem_we}, 32'd0);
        check("abort.cpu_rst2", {31'd0, w_cpu_rst}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
